multi_data_sync: RTL and testbench

MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

---
 rtl/multi_data_sync.sv | 96 +++++++++
 tb/tb_multi_data_sync.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_data_sync.sv
// rtl/multi_data_sync.sv - multi-channel enable-qualified bus synchroniser with capture handshake
//
// Each channel synchronises its own enable through NO_STAGES flops plus one
// history flop. A detected event (rising edge, or either edge when MODE=1)
// captures that channel's async bus word, which is held stable by the source
// while the enable propagates. Only the enable is synchronised; the bus word
// is sampled as a whole.
//
// Ports:
//   i_clk            destination clock
//   i_arst_n         asynchronous active-low reset
//   i_bus_enable     per-channel async qualifier
//   i_async_bus      per-channel async data, channel c at [c*BUS +: BUS]
//   i_ready          per-channel consumer accept
//   i_overrun_clr    per-channel clear of sticky overrun
//   o_synced_bus     captured data, same packing as i_async_bus
//   o_enable_pulse   one-cycle strobe following each capture
//   o_valid          captured word pending
//   o_overrun        sticky: pending word was overwritten
//   o_cap_cnt        per-channel capture count, channel c at [c*CNT_W +: CNT_W]

module multi_data_sync #(
    parameter int NO_STAGES = 2,
    parameter int BUS       = 8,
    parameter int CHANNELS  = 4,
    parameter int MODE      = 0,
    parameter int CNT_W     = 8
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic [CHANNELS-1:0]       i_bus_enable,
    input  logic [CHANNELS*BUS-1:0]   i_async_bus,
    input  logic [CHANNELS-1:0]       i_ready,
    input  logic [CHANNELS-1:0]       i_overrun_clr,
    output logic [CHANNELS*BUS-1:0]   o_synced_bus,
    output logic [CHANNELS-1:0]       o_enable_pulse,
    output logic [CHANNELS-1:0]       o_valid,
    output logic [CHANNELS-1:0]       o_overrun,
    output logic [CHANNELS*CNT_W-1:0] o_cap_cnt
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [NO_STAGES-1:0] sync_q;
        logic                 s;
        logic                 s_d;
        logic                 event_det;
        logic [BUS-1:0]       data_q;
        logic                 pulse_q;
        logic                 valid_q;
        logic                 overrun_q;
        logic [CNT_W-1:0]     cnt_q;

        assign s = sync_q[NO_STAGES-1];

        // Because the chain resets to 0, an enable held high through reset
        // release shows up as a rising edge and produces exactly one capture.
        if (MODE == 1) begin : g_toggle
            assign event_det = s ^ s_d;
        end else begin : g_rise
            assign event_det = s & ~s_d;
        end

        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                sync_q    <= '0;
                s_d       <= 1'b0;
                data_q    <= '0;
                pulse_q   <= 1'b0;
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync_q  <= {sync_q[NO_STAGES-2:0], i_bus_enable[c]};
                s_d     <= s;
                pulse_q <= event_det;
                if (event_det) begin
                    data_q <= i_async_bus[c*BUS +: BUS];
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                // A capture keeps the word pending even when the consumer
                // accepts in the same cycle: the accept takes the old word.
                valid_q   <= event_det | (valid_q & ~i_ready[c]);
                // A new overrun wins over a simultaneous clear.
                overrun_q <= (overrun_q & ~i_overrun_clr[c])
                           | (event_det & valid_q & ~i_ready[c]);
            end
        end

        assign o_synced_bus[c*BUS +: BUS]     = data_q;
        assign o_enable_pulse[c]              = pulse_q;
        assign o_valid[c]                     = valid_q;
        assign o_overrun[c]                   = overrun_q;
        assign o_cap_cnt[c*CNT_W +: CNT_W]    = cnt_q;
    end

endmodule

// File: tb/tb_multi_data_sync.sv
// tb/tb_multi_data_sync.sv - self-checking bench for multi_data_sync (rising-edge and toggle instances)

module tb_multi_data_sync;

    localparam int NS = 2;
    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  en = '0;
    logic [31:0] bus = '0;
    logic [3:0]  ready = '0;
    logic [3:0]  clr = '0;

    logic [31:0] syn0, syn1;
    logic [3:0]  pul0, pul1, val0, val1, ovr0, ovr1;
    logic [31:0] cnt0;
    logic [7:0]  cnt1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multi_data_sync #(.NO_STAGES(NS), .BUS(8), .CHANNELS(CH), .MODE(0), .CNT_W(8)) u0 (
        .i_clk(clk), .i_arst_n(rst_n), .i_bus_enable(en), .i_async_bus(bus),
        .i_ready(ready), .i_overrun_clr(clr), .o_synced_bus(syn0),
        .o_enable_pulse(pul0), .o_valid(val0), .o_overrun(ovr0), .o_cap_cnt(cnt0));

    multi_data_sync #(.NO_STAGES(NS), .BUS(8), .CHANNELS(CH), .MODE(1), .CNT_W(2)) u1 (
        .i_clk(clk), .i_arst_n(rst_n), .i_bus_enable(en), .i_async_bus(bus),
        .i_ready(ready), .i_overrun_clr(clr), .o_synced_bus(syn1),
        .o_enable_pulse(pul1), .o_valid(val1), .o_overrun(ovr1), .o_cap_cnt(cnt1));

    // Model: per instance/channel, the enable as the destination sees it is the
    // sample taken NS edges ago; the previous view is the sample NS+1 edges ago.
    bit       smp   [2][CH][NS+1];
    bit [7:0] m_data[2][CH];
    bit       m_pul [2][CH];
    bit       m_val [2][CH];
    bit       m_ovr [2][CH];
    int       m_cnt [2][CH];

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k <= NS; k++) smp[i][c][k] = 1'b0;
                m_data[i][c] = '0; m_pul[i][c] = 0; m_val[i][c] = 0;
                m_ovr[i][c] = 0;   m_cnt[i][c] = 0;
            end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++) begin
                    bit now_seen, prev_seen, ev;
                    now_seen  = smp[i][c][NS-1];
                    prev_seen = smp[i][c][NS];
                    ev = (i == 1) ? (now_seen != prev_seen) : (now_seen && !prev_seen);
                    m_ovr[i][c] = (m_ovr[i][c] && !clr[c]) || (ev && m_val[i][c] && !ready[c]);
                    if (ev) begin
                        m_data[i][c] = bus[c*8 +: 8];
                        m_val[i][c]  = 1;
                        m_cnt[i][c]  = (m_cnt[i][c] + 1) % ((i == 1) ? 4 : 256);
                    end else if (m_val[i][c] && ready[c]) begin
                        m_val[i][c] = 0;
                    end
                    m_pul[i][c] = ev;
                    for (int k = NS; k > 0; k--) smp[i][c][k] = smp[i][c][k-1];
                    smp[i][c][0] = en[c];
                end
        end
    end

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d at %0t: got %0h expected %0h", name, c, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
                chk("u0 data",  c, 64'(syn0[c*8 +: 8]), 64'(m_data[0][c]));
                chk("u0 pulse", c, 64'(pul0[c]),        64'(m_pul[0][c]));
                chk("u0 valid", c, 64'(val0[c]),        64'(m_val[0][c]));
                chk("u0 ovr",   c, 64'(ovr0[c]),        64'(m_ovr[0][c]));
                chk("u0 cnt",   c, 64'(cnt0[c*8 +: 8]), 64'(m_cnt[0][c]));
                chk("u1 data",  c, 64'(syn1[c*8 +: 8]), 64'(m_data[1][c]));
                chk("u1 pulse", c, 64'(pul1[c]),        64'(m_pul[1][c]));
                chk("u1 valid", c, 64'(val1[c]),        64'(m_val[1][c]));
                chk("u1 ovr",   c, 64'(ovr1[c]),        64'(m_ovr[1][c]));
                chk("u1 cnt",   c, 64'(cnt1[c*2 +: 2]), 64'(m_cnt[1][c]));
            end
        end
    end

    task automatic wn(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd2, 2'd3, 2'd0, 2'd1};

        wn(1);
        chk_en = 1'b1;
        wn(2);
        chk("reset valid", 0, 64'(val0), 64'h0);
        chk("reset cnt",   0, 64'(cnt0), 64'h0);
        rst_n = 1'b1;
        wn(2);

        // Rising enable on ch0 with 0xA5: capture after edge NS+1.
        bus[7:0] = 8'hA5; en[0] = 1'b1;
        wn(3);
        chk("lit A5 data",  0, 64'(syn0[7:0]), 64'hA5);
        chk("lit A5 pulse", 0, 64'(pul0[0]),   64'h1);
        chk("lit A5 valid", 0, 64'(val0[0]),   64'h1);
        chk("lit A5 cnt",   0, 64'(cnt0[7:0]), 64'h1);
        wn(1);
        chk("lit A5 pulse low", 0, 64'(pul0[0]), 64'h0);

        // Falling enable: no capture in rising mode, capture in toggle mode.
        bus[7:0] = 8'h5A; en[0] = 1'b0;
        wn(4);
        chk("lit fall u0 cnt",  0, 64'(cnt0[7:0]), 64'h1);
        chk("lit fall u0 data", 0, 64'(syn0[7:0]), 64'hA5);
        chk("lit fall u1 cnt",  0, 64'(cnt1[1:0]), 64'h2);
        chk("lit fall u1 data", 0, 64'(syn1[7:0]), 64'h5A);
        ready[0] = 1'b1; wn(1); ready[0] = 1'b0;

        // Two rising events on ch1 without accept: latest wins, overrun.
        bus[15:8] = 8'h11; en[1] = 1'b1; wn(4);
        en[1] = 1'b0; wn(4);
        bus[15:8] = 8'h22; en[1] = 1'b1; wn(4);
        chk("lit ovr data",  1, 64'(syn0[15:8]), 64'h22);
        chk("lit ovr set",   1, 64'(ovr0[1]),    64'h1);
        chk("lit ovr valid", 1, 64'(val0[1]),    64'h1);
        clr[1] = 1'b1; wn(1); clr[1] = 1'b0;
        chk("lit ovr clr", 1, 64'(ovr0[1]), 64'h0);
        ready[1] = 1'b1; wn(1); ready[1] = 1'b0;
        chk("lit accept valid", 1, 64'(val0[1]), 64'h0);

        // Accept coinciding with a new capture on ch2.
        bus[23:16] = 8'h33; en[2] = 1'b1; wn(4);
        en[2] = 1'b0; wn(4);
        bus[23:16] = 8'h44; en[2] = 1'b1; wn(2);
        ready[2] = 1'b1; wn(1); ready[2] = 1'b0;
        chk("lit same valid", 2, 64'(val0[2]),     64'h1);
        chk("lit same data",  2, 64'(syn0[23:16]), 64'h44);
        chk("lit same ovr",   2, 64'(ovr0[2]),     64'h0);
        chk("lit same pulse", 2, 64'(pul0[2]),     64'h1);

        // Overrun set, then a clear coinciding with a fresh overrun.
        en[2] = 1'b0; wn(4);
        bus[23:16] = 8'h50; en[2] = 1'b1; wn(4);
        chk("lit ovr2 set", 2, 64'(ovr0[2]), 64'h1);
        en[2] = 1'b0; wn(4);
        bus[23:16] = 8'h66; en[2] = 1'b1; wn(2);
        clr[2] = 1'b1; wn(1); clr[2] = 1'b0;
        chk("lit clr+ovr",  2, 64'(ovr0[2]),     64'h1);
        chk("lit clr data", 2, 64'(syn0[23:16]), 64'h66);

        // Quiet other channels, then reset mid-synchronisation on ch0.
        en[3:1] = '0; wn(4);
        en[0] = 1'b1; wn(1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit rst syn",  0, 64'(syn0), 64'h0);
        chk("lit rst val",  0, 64'({val0, val1, ovr0, ovr1, pul0, pul1}), 64'h0);
        chk("lit rst cnt",  0, 64'({cnt0, cnt1}), 64'h0);
        wn(2);
        rst_n = 1'b1;
        wn(3);
        chk("lit rel pulse",  0, 64'(pul0[0]),   64'h1);
        chk("lit rel u0 cnt", 0, 64'(cnt0[7:0]), 64'h1);
        chk("lit rel u1 cnt", 0, 64'(cnt1[1:0]), 64'h1);
        chk("lit rel val2",   2, 64'(val0[2]),   64'h0);
        wn(4);
        chk("lit rel once", 0, 64'(cnt0[7:0]), 64'h1);

        // Toggle-mode counter wrap at width 2: 1,2,3,0,1.
        for (int k = 0; k < 4; k++) begin
            en[0] = ~en[0];
            wn(4);
            chk("lit wrap cnt", 0, 64'(cnt1[1:0]), 64'(exp_seq[k]));
        end
        chk("lit idle u1 cnt", 1, 64'(cnt1[7:2]),  64'h0);
        chk("lit idle u0 cnt", 1, 64'(cnt0[31:8]), 64'h0);

        wn(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
